// File: rtl/bus_responder_pkg.sv
// Shared encodings for the snooping bus responder: bus ops, snoop results and FSM states.
package bus_responder_pkg;

  localparam int unsigned OP_W       = 2;
  localparam int unsigned SNP_W      = 2;
  localparam int unsigned HITM_CNT_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_READ       = 2'd0,
    OP_WRITE      = 2'd1,
    OP_RFO        = 2'd2,
    OP_INVALIDATE = 2'd3
  } bus_op_e;

  typedef enum logic [SNP_W-1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snp_res_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_WB    = 3'd2,
    ST_MEM   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // The unused 2'b11 code from the peers is folded into HITM.
  function automatic snp_res_e snp_norm(input logic [SNP_W-1:0] raw);
    snp_norm = (raw == 2'b11) ? SNP_HITM : snp_res_e'(raw);
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Requester, snoop, memory and response signals of the bus responder.
interface bus_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;

  logic              snp_valid;
  logic [1:0]        snp_op;
  logic [ADDR_W-1:0] snp_addr;
  logic              snp_res_valid;
  logic [1:0]        snp_res;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;

  logic              rsp_valid;
  logic [1:0]        rsp_snoop;
  logic              rsp_err;
  logic [15:0]       hitm_cnt;

  modport slave (
    input  req_valid, req_op, req_addr, snp_res_valid, snp_res, mem_done,
    output req_ready, snp_valid, snp_op, snp_addr, mem_valid, mem_we, mem_addr,
           rsp_valid, rsp_snoop, rsp_err, hitm_cnt
  );

  modport master (
    output req_valid, req_op, req_addr, snp_res_valid, snp_res, mem_done,
    input  req_ready, snp_valid, snp_op, snp_addr, mem_valid, mem_we, mem_addr,
           rsp_valid, rsp_snoop, rsp_err, hitm_cnt
  );
endinterface

// File: rtl/bus_responder_snoop_timer.sv
// Snoop timeout counter: cleared outside SNOOP, counts SNOOP cycles, flags the last allowed cycle.
module bus_responder_snoop_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_start,
  output logic o_expired_c
);
  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Expiry fires on the LIMIT-th SNOOP cycle, i.e. once LIMIT cycles have been spent waiting.
  assign o_expired_c = i_start && (r_cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start && !o_expired_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/bus_responder.sv
// Snooping bus responder: broadcasts a snoop, flushes a peer's dirty line when needed,
// performs the memory access and returns a one-cycle completion with the snoop result.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SNP_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_responder_if.slave  bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  bus_op_e           r_op;
  logic [ADDR_W-1:0] r_addr;
  snp_res_e          r_res;
  logic              r_err;
  logic [HITM_CNT_W-1:0] r_hitm_cnt;

  logic r_req_ready, r_snp_valid, r_mem_valid, r_mem_we, r_rsp_valid;
  logic w_req_ready_nxt, w_snp_valid_nxt, w_mem_valid_nxt, w_mem_we_nxt, w_rsp_valid_nxt;

  snp_res_e w_res_now;
  logic     w_snoop_done;
  logic     w_tmr_start;
  logic     w_tmr_clear;
  logic     w_tmr_expired;

  assign w_tmr_start = (r_state == ST_SNOOP);
  assign w_tmr_clear = !w_tmr_start;

  bus_responder_snoop_timer #(
    .LIMIT(SNP_TIMEOUT)
  ) u_snoop_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_tmr_clear),
    .i_start    (w_tmr_start),
    .o_expired_c(w_tmr_expired)
  );

  // Next state plus the registered-output values that follow from it.
  always_comb begin
    w_state_nxt  = r_state;
    w_res_now    = bus.snp_res_valid ? snp_norm(bus.snp_res) : SNP_NOHIT;
    w_snoop_done = bus.snp_res_valid || w_tmr_expired;

    case (r_state)
      ST_IDLE:  if (bus.req_valid) w_state_nxt = ST_SNOOP;
      ST_SNOOP: begin
        if (w_snoop_done) begin
          if (w_res_now == SNP_HITM && (r_op == OP_READ || r_op == OP_RFO)) begin
            w_state_nxt = ST_WB;
          end else if (r_op == OP_INVALIDATE) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_MEM;
          end
        end
      end
      ST_WB:    if (bus.mem_done) w_state_nxt = ST_MEM;
      ST_MEM:   if (bus.mem_done) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    w_snp_valid_nxt = (w_state_nxt == ST_SNOOP);
    w_mem_valid_nxt = (w_state_nxt == ST_WB) || (w_state_nxt == ST_MEM);
    // The WB flush writes; after a flush the MEM access is always a read (only READ/RFO reach WB).
    w_mem_we_nxt    = (w_state_nxt == ST_WB) || (w_state_nxt == ST_MEM && r_op == OP_WRITE);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_snp_valid <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_snp_valid <= w_snp_valid_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  // Operation context: request latched on accept, snoop outcome latched when SNOOP ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_READ;
      r_addr     <= '0;
      r_res      <= SNP_NOHIT;
      r_err      <= 1'b0;
      r_hitm_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.req_valid) begin
        r_op   <= bus_op_e'(bus.req_op);
        r_addr <= bus.req_addr;
      end
      if (r_state == ST_SNOOP && w_snoop_done) begin
        r_res <= w_res_now;
        r_err <= !bus.snp_res_valid;
      end
      if (r_state == ST_RESP && r_res == SNP_HITM && r_hitm_cnt != '1) begin
        r_hitm_cnt <= r_hitm_cnt + HITM_CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.snp_valid = r_snp_valid;
  assign bus.snp_op    = r_op;
  assign bus.snp_addr  = r_addr;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_snoop = r_res;
  assign bus.rsp_err   = r_err;
  assign bus.hitm_cnt  = r_hitm_cnt;

endmodule

// File: tb/tb_bus_responder.sv
// Directed plus randomized bench for bus_responder; peers and memory are played reactively
// and every operation is compared with an outcome model built from the protocol rules.
module tb_bus_responder;
  import bus_responder_pkg::*;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned SNP_TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_responder_if #(.ADDR_W(ADDR_W)) bus ();

  bus_responder #(
    .ADDR_W     (ADDR_W),
    .SNP_TIMEOUT(SNP_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks     = 0;
  int failures   = 0;
  int hitm_model = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete bus operation: drive request, answer snoop and memory, compare with the model.
  task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input int snp_delay, input logic [1:0] snp_val,
                        input int mem_delay, input bit keep, input string tag);
    logic [1:0]      eff;
    bit              tmo;
    int              exp_snp_cyc, exp_lat;
    logic [ADDR_W:0] exp_acc[$];
    logic [ADDR_W:0] obs_acc[$];
    int              t, snp_k, mem_k, lat;
    bit              done, new_acc, ready_busy, op_ok;
    logic [1:0]      o_snp;
    logic            o_err;

    // Expected outcome from the protocol rules.
    tmo = (snp_delay >= int'(SNP_TIMEOUT));
    eff = tmo ? 2'd0 : ((snp_val == 2'd3) ? 2'd2 : snp_val);
    if (op == 2'd3) begin
    end else if (op != 2'd1 && eff == 2'd2) begin
      exp_acc.push_back({1'b1, addr});
      exp_acc.push_back({1'b0, addr});
    end else begin
      exp_acc.push_back({(op == 2'd1), addr});
    end
    exp_snp_cyc = tmo ? int'(SNP_TIMEOUT) : snp_delay + 1;
    exp_lat     = 1 + exp_snp_cyc + exp_acc.size() * (mem_delay + 1);
    if (eff == 2'd2 && hitm_model < 65535) hitm_model++;

    t = 0;
    while (bus.req_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check({tag, ":idle"}, 64'(bus.req_ready), 64'd1);

    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    t = 0; snp_k = 0; mem_k = 0; lat = 0;
    done = 0; new_acc = 1; ready_busy = 0; op_ok = 1;
    o_snp = 2'd0; o_err = 1'b0;

    while (!done && t < 400) begin
      @(posedge clk); #1; t++;
      bus.snp_res_valid = 1'b0;
      bus.mem_done      = 1'b0;
      if (t == 1) begin
        if (keep) begin
          bus.req_op   = ~op;
          bus.req_addr = ~addr;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      if (bus.req_ready) ready_busy = 1;
      if (bus.snp_valid) begin
        if (bus.snp_op !== op || bus.snp_addr !== addr) op_ok = 0;
        if (snp_k == snp_delay) begin
          bus.snp_res_valid = 1'b1;
          bus.snp_res       = snp_val;
        end else begin
          bus.snp_res = 2'($urandom_range(0, 3));
        end
        snp_k++;
      end
      if (bus.mem_valid) begin
        if (new_acc) begin
          obs_acc.push_back({bus.mem_we, bus.mem_addr});
          mem_k   = 0;
          new_acc = 0;
        end
        if (mem_k == mem_delay) begin
          bus.mem_done = 1'b1;
          new_acc      = 1;
        end
        mem_k++;
      end else begin
        bus.mem_done = 1'($urandom_range(0, 1));
      end
      if (bus.rsp_valid) begin
        done  = 1;
        lat   = t;
        o_snp = bus.rsp_snoop;
        o_err = bus.rsp_err;
      end
    end

    check({tag, ":rsp_seen"},   64'(done),          64'd1);
    check({tag, ":latency"},    64'(lat),           64'(exp_lat));
    check({tag, ":rsp_snoop"},  64'(o_snp),         64'(eff));
    check({tag, ":rsp_err"},    64'(o_err),         64'(tmo));
    check({tag, ":snp_cycles"}, 64'(snp_k),         64'(exp_snp_cyc));
    check({tag, ":snp_opaddr"}, 64'(op_ok),         64'd1);
    check({tag, ":busy_ready"}, 64'(ready_busy),    64'd0);
    check({tag, ":n_mem"},      64'(obs_acc.size()), 64'(exp_acc.size()));
    for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++)
      check($sformatf("%s:mem%0d", tag, i), 64'(obs_acc[i]), 64'(exp_acc[i]));

    @(posedge clk); #1;
    bus.mem_done = 1'b0;
    check({tag, ":rsp_pulse"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, ":ready_after"}, 64'(bus.req_ready), 64'd1);
    check({tag, ":hitm_cnt"}, 64'(bus.hitm_cnt), 64'(hitm_model));
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_op        = 2'd0;
    bus.req_addr      = '0;
    bus.snp_res_valid = 1'b0;
    bus.snp_res       = 2'd0;
    bus.mem_done      = 1'b0;

    // Reset values.
    #12;
    check("rst:req_ready", 64'(bus.req_ready), 64'd1);
    check("rst:snp_valid", 64'(bus.snp_valid), 64'd0);
    check("rst:mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst:mem_we",    64'(bus.mem_we),    64'd0);
    check("rst:rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst:rsp_snoop", 64'(bus.rsp_snoop), 64'd0);
    check("rst:rsp_err",   64'(bus.rsp_err),   64'd0);
    check("rst:hitm_cnt",  64'(bus.hitm_cnt),  64'd0);
    check("rst:snp_addr",  64'(bus.snp_addr),  64'd0);
    check("rst:snp_op",    64'(bus.snp_op),    64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(OP_READ,       32'h0000_1000, 0,  2'd0, 0, 1'b0, "rd_min");
    run_op(OP_RFO,        32'h0000_2040, 1,  2'd2, 1, 1'b0, "rfo_hitm");
    run_op(OP_INVALIDATE, 32'h0000_3000, 0,  2'd1, 0, 1'b0, "inv_hit");
    run_op(OP_READ,       32'h0000_5000, 40, 2'd2, 0, 1'b0, "rd_timeout");
    run_op(OP_READ,       32'h0000_6000, 14, 2'd2, 2, 1'b0, "rd_last_cycle");
    run_op(OP_WRITE,      32'h0000_7000, 2,  2'd3, 0, 1'b0, "wr_code3");
    run_op(OP_WRITE,      32'h0000_8000, 0,  2'd0, 3, 1'b0, "wr_plain");

    // Back-to-back with req_valid held high and the request lines scrambled while busy.
    run_op(OP_READ,       32'h0000_9000, 1,  2'd0, 0, 1'b1, "b2b_0");
    run_op(OP_RFO,        32'h0000_9040, 0,  2'd2, 0, 1'b1, "b2b_1");
    run_op(OP_WRITE,      32'h0000_9080, 0,  2'd1, 1, 1'b0, "b2b_2");

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom_range(0, 3)), 32'($urandom), int'($urandom_range(0, 17)),
             2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", n));
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;

    // Reset during the memory phase abandons the operation.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_READ;
    bus.req_addr  = 32'h0000_4000;
    @(posedge clk); #1;
    bus.req_valid     = 1'b0;
    bus.snp_res_valid = 1'b1;
    bus.snp_res       = 2'd0;
    @(posedge clk); #1;
    bus.snp_res_valid = 1'b0;
    check("mrst:mem_valid_before", 64'(bus.mem_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst:mem_valid_async", 64'(bus.mem_valid), 64'd0);
    check("mrst:req_ready",       64'(bus.req_ready), 64'd1);
    check("mrst:hitm_cnt",        64'(bus.hitm_cnt),  64'd0);
    hitm_model = 0;
    repeat (2) begin
      @(posedge clk); #1;
      check("mrst:rsp_valid_in_rst", 64'(bus.rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("mrst:rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
      check("mrst:ready_after",     64'(bus.req_ready), 64'd1);
      check("mrst:mem_idle",        64'(bus.mem_valid), 64'd0);
    end
    run_op(OP_RFO, 32'h0000_A000, 0, 2'd2, 0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter SNP_TIMEOUT, default 15, max cycles waiting for snoop result.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  requester presents bus operation.
REQ-006 req_ready  out  1  responder idle, can accept.
REQ-007 req_op  in  2  bus op: READ, WRITE, RFO, INVALIDATE.
REQ-008 req_addr  in  ADDR_W  line address of operation.
REQ-009 snp_valid  out  1  snoop broadcast to peer caches active.
REQ-010 snp_op, snp_addr  out  2 / ADDR_W  latched op and address.
REQ-011 snp_res_valid  in  1  peers' combined snoop result valid.
REQ-012 snp_res  in  2  NOHIT, HIT, HITM.
REQ-013 mem_valid, mem_we, mem_addr  out  1 / 1 / ADDR_W  memory access request.
REQ-014 mem_done  in  1  memory access complete.
REQ-015 rsp_valid, rsp_snoop, rsp_err  out  1 / 2 / 1  completion pulse, final snoop result, timeout flag.
REQ-016 hitm_cnt  out  16  count of completed ops whose snoop result was HITM.

Function
REQ-017 FSM states SHALL be IDLE, SNOOP, WB, MEM, RESP.
REQ-018 IDLE: req_ready=1; on req_valid, latch req_op/req_addr and go to SNOOP next cycle; req_ready=0 in all other states.
REQ-019 SNOOP: snp_valid=1 with latched op/addr until a cycle with snp_res_valid=1; result latched that cycle, snp_valid=0 next cycle.
REQ-020 SNOOP timeout: cycle counter starts at 0 on SNOOP entry; if it reaches SNP_TIMEOUT with no snp_res_valid, result=NOHIT, rsp_err=1 for this op; snp_res_valid on the timeout cycle takes priority (no error).
REQ-021 Next state after SNOOP: HITM with READ or RFO -> WB; INVALIDATE -> RESP; WRITE -> MEM (write); READ/RFO otherwise -> MEM (read).
REQ-022 WB: mem_valid=1, mem_we=1, mem_addr=latched addr (peer's dirty line flushed), held until mem_done, then MEM (read).
REQ-023 MEM: mem_valid=1, mem_we per REQ-021, held until mem_done; then RESP.
REQ-024 mem_valid SHALL drop the cycle after mem_done is sampled high; mem_done while mem_valid=0 is ignored.
REQ-025 RESP: rsp_valid=1 exactly one cycle with rsp_snoop and rsp_err; then IDLE; new request accepted no earlier than the cycle after RESP.
REQ-026 Minimum latency READ, NOHIT, 1-cycle snoop and memory: accept -> rsp_valid in 4 cycles.
REQ-027 hitm_cnt increments in RESP when rsp_snoop=HITM; saturates at 16'hFFFF.
REQ-028 snp_res encoding 2'b11 SHALL be treated as HITM.

Reset
REQ-029 On rst_n low: state=IDLE, req_ready=1, snp_valid=0, mem_valid=0, mem_we=0, rsp_valid=0, rsp_snoop=NOHIT, rsp_err=0, hitm_cnt=0, latched addr/op=0, timeout counter=0.
REQ-030 Reset mid-operation SHALL abandon the op immediately with no rsp_valid pulse; mem_valid deasserts asynchronously.

Structure
REQ-031 Shared package SHALL hold bus-op encoding (READ=0, WRITE=1, RFO=2, INVALIDATE=3), snoop-result encoding (NOHIT=0, HIT=1, HITM=2) and FSM state type.
REQ-032 One sub-module, snoop_timer, SHALL implement the SNOOP timeout counter (start, clear, expired).

Verification
REQ-033 READ 0x0000_1000, snp_res=NOHIT after 1 cycle, mem_done after 1 cycle -> one mem read at 0x1000, rsp_valid in cycle 4, rsp_snoop=NOHIT.
REQ-034 RFO 0x0000_2040, snp_res=HITM -> mem write at 0x2040 then mem read at 0x2040, rsp_snoop=HITM, hitm_cnt=1.
REQ-035 INVALIDATE 0x0000_3000, snp_res=HIT -> no mem_valid, rsp_snoop=HIT, rsp_err=0.
REQ-036 READ with no snp_res_valid for 15 cycles -> rsp_err=1, rsp_snoop=NOHIT, mem read issued.
REQ-037 rst_n low during MEM with mem_valid=1 -> mem_valid=0 immediately, no rsp_valid, req_ready=1 after release.
REQ-038 Back-to-back requests with req_valid held high -> second accepted only after first rsp_valid; req_op changes while busy ignored.
